// File: rtl/fp_posit_mul_lanes.sv
// Bit-serial sign-magnitude posit weight, MSB first, broadcast to LANES FP activations.
// Optional `FP_POSIT_NAR_EN adds a registered NaR flag output (nar).
module fp_posit_mul_lanes #(
    parameter int LANES         = 4,
    parameter int ACT_WIDTH     = 16,
    parameter int EXP_WIDTH     = 5,
    parameter int MAN_WIDTH     = 10,
    parameter int PMAX          = 8,
    parameter int ES            = 1,
    parameter int WFRAC         = 5,
    parameter int EXP_OUT_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [LANES*ACT_WIDTH-1:0]              act,
    input  logic                                    w,
    input  logic                                    valid,
    input  logic                                    set,
    input  logic [3:0]                              precision,
    output logic [LANES-1:0]                        sign_out,
    output logic [LANES*EXP_OUT_WIDTH-1:0]          exp_out,
    output logic [LANES*(MAN_WIDTH+WFRAC+2)-1:0]    man_out,
    output logic                                    start_acc,
`ifdef FP_POSIT_NAR_EN
    output logic                                    nar,
`endif
    output logic                                    done
);
    localparam int CW  = $clog2(PMAX + 1);
    localparam int EW  = (ES > 0) ? ES : 1;
    localparam int MW  = MAN_WIDTH + WFRAC + 2;
    localparam int EOW = EXP_OUT_WIDTH;

    // The sign bit is consumed in IDLE so that back-to-back words need no bubble.
    typedef enum logic [1:0] {IDLE, REGIME, EXP, FRAC} state_t;

    state_t                     state, nxt_state;
    logic [CW-1:0]              cnt, nxt_cnt;
    logic [CW-1:0]              prec, prec_clamped;
    logic                       w_sign, nxt_sign;
    logic                       r0, nxt_r0;
    logic [CW-1:0]              run, nxt_run;
    logic [EW-1:0]              e_reg, nxt_e;
    logic [WFRAC-1:0]           frac_reg, nxt_frac;
    logic [CW-1:0]              idx, nxt_idx;
    logic                       nz, nxt_nz;
    logic                       last;
    logic [LANES*ACT_WIDTH-1:0] act_reg;

    logic [EOW-1:0]             k_val, scale;
    logic                       w_nar;
    logic [LANES-1:0]           nxt_sign_out;
    logic [LANES*EOW-1:0]       nxt_exp_out;
    logic [LANES*MW-1:0]        nxt_man_out;
    logic [EXP_WIDTH-1:0]       a_exp;
    logic [MAN_WIDTH-1:0]       a_man;

    always_comb begin
        if (int'(precision) < 3)
            prec_clamped = CW'(3);
        else if (int'(precision) > PMAX)
            prec_clamped = CW'(PMAX);
        else
            prec_clamped = CW'(precision);
    end

    // Bit decoder: every field register is updated with the current bit so the final
    // values are available combinationally on the cycle that consumes the last bit.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_sign  = w_sign;
        nxt_r0    = r0;
        nxt_run   = run;
        nxt_e     = e_reg;
        nxt_frac  = frac_reg;
        nxt_idx   = idx;
        nxt_nz    = nz;
        last      = 1'b0;
        if (valid) begin
            nxt_cnt = cnt + CW'(1);
            last    = (nxt_cnt == prec);
            case (state)
                IDLE: begin
                    nxt_sign  = w;
                    nxt_r0    = 1'b0;
                    nxt_run   = '0;
                    nxt_e     = '0;
                    nxt_frac  = '0;
                    nxt_idx   = '0;
                    nxt_nz    = 1'b0;
                    nxt_state = REGIME;
                end
                REGIME: begin
                    nxt_nz = nz | w;
                    if (run == '0) begin
                        nxt_r0  = w;
                        nxt_run = CW'(1);
                    end else if (w == r0) begin
                        nxt_run = run + CW'(1);
                    end else begin
                        nxt_idx   = '0;
                        nxt_state = (ES > 0) ? EXP : FRAC;
                    end
                end
                EXP: begin
                    nxt_nz = nz | w;
                    nxt_e[EW-1-int'(idx)] = w;
                    if (int'(idx) >= ES - 1) begin
                        nxt_idx   = '0;
                        nxt_state = FRAC;
                    end else begin
                        nxt_idx = idx + CW'(1);
                    end
                end
                FRAC: begin
                    nxt_nz = nz | w;
                    if (int'(idx) < WFRAC)
                        nxt_frac[WFRAC-1-int'(idx)] = w;
                    nxt_idx = idx + CW'(1);
                end
                default: nxt_state = IDLE;
            endcase
            if (last) begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        end
    end

    // Per-lane products from the fully decoded weight; an all-zero magnitude is a zero weight.
    always_comb begin
        k_val        = nxt_r0 ? (EOW'(nxt_run) - EOW'(1)) : (EOW'(0) - EOW'(nxt_run));
        scale        = (k_val << ES) + EOW'(nxt_e);
        w_nar        = nxt_sign & ~nxt_nz;
        nxt_sign_out = '0;
        nxt_exp_out  = '0;
        nxt_man_out  = '0;
        a_exp        = '0;
        a_man        = '0;
        for (int i = 0; i < LANES; i++) begin
            a_exp = act_reg[i*ACT_WIDTH + MAN_WIDTH +: EXP_WIDTH];
            a_man = act_reg[i*ACT_WIDTH +: MAN_WIDTH];
            nxt_sign_out[i] = act_reg[i*ACT_WIDTH + ACT_WIDTH - 1] ^ nxt_sign;
            if ((a_exp != '0) && nxt_nz) begin
                nxt_exp_out[i*EOW +: EOW] = EOW'(a_exp) + scale;
                nxt_man_out[i*MW +: MW]   = MW'({1'b1, a_man}) * MW'({1'b1, nxt_frac});
            end
`ifdef FP_POSIT_NAR_EN
            if (w_nar)
                nxt_sign_out[i] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prec      <= CW'(PMAX);
            w_sign    <= 1'b0;
            r0        <= 1'b0;
            run       <= '0;
            e_reg     <= '0;
            frac_reg  <= '0;
            idx       <= '0;
            nz        <= 1'b0;
            act_reg   <= '0;
            sign_out  <= '0;
            exp_out   <= '0;
            man_out   <= '0;
            start_acc <= 1'b0;
            done      <= 1'b0;
`ifdef FP_POSIT_NAR_EN
            nar       <= 1'b0;
`endif
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            w_sign   <= nxt_sign;
            r0       <= nxt_r0;
            run      <= nxt_run;
            e_reg    <= nxt_e;
            frac_reg <= nxt_frac;
            idx      <= nxt_idx;
            nz       <= nxt_nz;
            if (state == IDLE && valid)
                act_reg <= act;
            if (state == IDLE && set)
                prec <= prec_clamped;
            done      <= last;
            start_acc <= last & nxt_nz;
            if (last) begin
                sign_out <= nxt_sign_out;
                exp_out  <= nxt_exp_out;
                man_out  <= nxt_man_out;
`ifdef FP_POSIT_NAR_EN
                nar      <= w_nar;
`endif
            end
        end
    end

`ifndef FP_POSIT_NAR_EN
    logic unused_nar;
    assign unused_nar = w_nar;
`endif

endmodule

// File: tb/tb_fp_posit_mul_lanes.sv
// Scoreboard bench for fp_posit_mul_lanes: independent posit decoder model, expectations queued per word.
// Honours `FP_POSIT_NAR_EN when the design is built with it.
module tb_fp_posit_mul_lanes;
    localparam int LANES = 4;
    localparam int AW    = 16;
    localparam int EOW   = 8;
    localparam int MW    = 17;
    localparam int ES    = 1;
    localparam int WFRAC = 5;

    typedef struct {
        int                     done_cyc;
        bit                     start;
        bit                     nar;
        logic [LANES-1:0]       sgn;
        logic [LANES*EOW-1:0]   ex;
        logic [LANES*MW-1:0]    mn;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES*AW-1:0]    act;
    logic                   w, valid, set;
    logic [3:0]             precision;
    logic [LANES-1:0]       sign_out;
    logic [LANES*EOW-1:0]   exp_out;
    logic [LANES*MW-1:0]    man_out;
    logic                   start_acc, done;
`ifdef FP_POSIT_NAR_EN
    logic                   nar;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    fp_posit_mul_lanes dut (
        .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .set(set),
        .precision(precision), .sign_out(sign_out), .exp_out(exp_out),
        .man_out(man_out), .start_acc(start_acc),
`ifdef FP_POSIT_NAR_EN
        .nar(nar),
`endif
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic int getBit(input int word, input int pos);
        return (pos >= 0) ? ((word >> pos) & 1) : 0;
    endfunction

    function automatic void decode(input int word, input int n, output bit ws, output bit wz,
                                   output int sc, output int fr);
        int  mag, pos, m, k, e;
        bit  rb;
        ws  = getBit(word, n - 1) != 0;
        mag = word & ((1 << (n - 1)) - 1);
        wz  = (mag == 0);
        pos = n - 2;
        rb  = getBit(mag, pos) != 0;
        m   = 0;
        while (pos >= 0 && (getBit(mag, pos) != 0) == rb) begin
            m++;
            pos--;
        end
        if (pos >= 0) pos--;
        k = rb ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + getBit(mag, pos);
            pos--;
        end
        fr = 0;
        for (int j = 0; j < WFRAC; j++) begin
            fr = fr * 2 + getBit(mag, pos);
            pos--;
        end
        sc = k * (1 << ES) + e;
    endfunction

    function automatic exp_t model(input int word, input int n, input logic [LANES*AW-1:0] acts);
        exp_t        r;
        bit          ws, wz;
        int          sc, fr;
        logic [15:0] a;
        int          ae, am;
        decode(word, n, ws, wz, sc, fr);
        r.done_cyc = 0;
        r.start    = !wz;
        r.nar      = 1'b0;
`ifdef FP_POSIT_NAR_EN
        r.nar      = ws && wz;
`endif
        r.sgn = '0;
        r.ex  = '0;
        r.mn  = '0;
        for (int i = 0; i < LANES; i++) begin
            a  = acts[i*AW +: AW];
            ae = int'(a[14:10]);
            am = int'(a[9:0]);
            r.sgn[i] = a[15] ^ ws;
            if (r.nar) r.sgn[i] = 1'b1;
            if (!wz && ae != 0) begin
                r.ex[i*EOW +: EOW] = EOW'(ae + sc);
                r.mn[i*MW +: MW]   = MW'((1024 + am) * (32 + fr));
            end
        end
        return r;
    endfunction

    function automatic int clampPrec(input int p);
        return (p < 3) ? 3 : ((p > 8) ? 8 : p);
    endfunction

    // Drives one n-bit word MSB first; optional stall before bit stall_at and an ignored mid-word set.
    task automatic applyStimulus(input int word, input int n, input logic [LANES*AW-1:0] acts,
                                 input int stall_at, input int stall_len, input bit mid_set);
        exp_t e;
        e = model(word, n, acts);
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    valid = 1'b0;
                    set   = 1'b0;
                end
            end
            @(negedge clk);
            valid = 1'b1;
            w     = ((word >> (n - 1 - b)) & 1) != 0;
            set   = mid_set && (b == 2);
            if (mid_set && b == 2) precision = 4'd3;
            if (b == 0) act = acts;
            if (b == n - 1) begin
                e.done_cyc = cyc + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        valid = 1'b0;
        w     = 1'b0;
        set   = 1'b0;
    endtask

    task automatic setPrecision(input int p);
        @(negedge clk);
        valid     = 1'b0;
        set       = 1'b1;
        precision = 4'(p);
        @(negedge clk);
        set = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 128'(1), 128'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("done_cycle", 128'(cyc), 128'(e.done_cyc));
                checkOutput("start_acc", 128'(start_acc), 128'(e.start));
                checkOutput("sign_out", 128'(sign_out), 128'(e.sgn));
                checkOutput("exp_out", 128'(exp_out), 128'(e.ex));
                checkOutput("man_out", 128'(man_out), 128'(e.mn));
`ifdef FP_POSIT_NAR_EN
                checkOutput("nar", 128'(nar), 128'(e.nar));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=%0d expected=finish", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [LANES*AW-1:0] acts0, acts1, racts;
        int p, n, wd, wait_cnt;
        rst = 1'b0; valid = 1'b0; w = 1'b0; set = 1'b0; precision = 4'd0; act = '0;
        // lane0 = 0x3C00, lane1 = 0xC000, lane2 = zero, lane3 = 0x4A80
        acts0 = {16'h4A80, 16'h0000, 16'hC000, 16'h3C00};
        acts1 = {16'h3C00, 16'hBE00, 16'h0000, 16'h5555};
        repeat (3) @(negedge clk);
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_start_acc", 128'(start_acc), 128'(0));
        checkOutput("reset_sign_out", 128'(sign_out), 128'(0));
        checkOutput("reset_exp_out", 128'(exp_out), 128'(0));
        checkOutput("reset_man_out", 128'(man_out), 128'(0));
        rst = 1'b1;

        setPrecision(8);
        applyStimulus(8'h40, 8, acts0, -1, 0, 1'b0);
        applyStimulus(8'h60, 8, acts0, -1, 0, 1'b0);
        applyStimulus(8'h4C, 8, acts0, -1, 0, 1'b0);
        applyStimulus(8'h00, 8, acts0, -1, 0, 1'b0);
        applyStimulus(8'h80, 8, acts1, -1, 0, 1'b0);
        applyStimulus(8'hC4, 8, acts1, -1, 0, 1'b0);
        applyStimulus(8'h08, 8, acts0, -1, 0, 1'b0);
        applyStimulus(8'h7F, 8, acts0, -1, 0, 1'b1);
        idleCycle();
        applyStimulus(8'h4C, 8, acts0, 4, 3, 1'b0);
        idleCycle();

        setPrecision(4);
        applyStimulus(4'b0110, 4, acts0, -1, 0, 1'b0);
        applyStimulus(4'b1001, 4, acts1, -1, 0, 1'b0);
        applyStimulus(4'b0111, 4, acts0, -1, 0, 1'b0);
        idleCycle();
        setPrecision(2);
        applyStimulus(3'b011, 3, acts0, -1, 0, 1'b0);
        idleCycle();
        setPrecision(15);
        applyStimulus(8'h5A, 8, acts1, -1, 0, 1'b0);
        idleCycle();

        for (int t = 0; t < 10; t++) begin
            p     = int'($urandom_range(0, 15));
            n     = clampPrec(p);
            wd    = int'($urandom_range(0, 255)) & ((1 << n) - 1);
            racts = {$urandom, $urandom};
            setPrecision(p);
            applyStimulus(wd, n, racts, -1, 0, 1'b0);
            idleCycle();
        end

        idleCycle();
        idleCycle();
        setPrecision(8);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            valid = 1'b1;
            w     = (b == 1);
            if (b == 0) act = acts0;
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        checkOutput("midreset_man_out", 128'(man_out), 128'(0));
        checkOutput("midreset_done", 128'(done), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(8'h60, 8, acts0, -1, 0, 1'b0);
        idleCycle();

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("scoreboard_drain", 128'(sb.size()), 128'(0));
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
